// File: rtl/icache_2way.sv
// icache_2way: 2-way set-associative, read-only instruction cache.
//   Hits return the addressed word combinationally with zero wait; misses
//   stall the CPU, refill the whole line from memory into the victim way and
//   retry. A flush clears every valid and LRU bit in a single FLUSH cycle.
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_ni          asynchronous active-low reset
//   pc_i            fetch address (bits [1:0] and above ADDR_W-1 ignored)
//   pc_req_i        fetch request valid
//   flush_i         invalidate all lines
//   instruction_o   fetched word (0 when no hit or no request)
//   busywait_o      CPU stall
//   mem_read_o      line refill request
//   mem_address_o   refill line address {tag,index}
//   mem_readdata_i  refill line, word 0 in the LSBs
//   mem_busywait_i  memory not ready
module icache_2way #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned SETS        = 4,
  localparam int unsigned WSEL_W = $clog2(BLOCK_WORDS),
  localparam int unsigned OFF_W  = WSEL_W + 2,
  localparam int unsigned IDX_W  = $clog2(SETS),
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W,
  localparam int unsigned BLK_W  = ADDR_W - OFF_W,
  localparam int unsigned LINE_W = 32 * BLOCK_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       pc_i,
  input  logic              pc_req_i,
  input  logic              flush_i,
  output logic [31:0]       instruction_o,
  output logic              busywait_o,
  output logic              mem_read_o,
  output logic [BLK_W-1:0]  mem_address_o,
  input  logic [LINE_W-1:0] mem_readdata_i,
  input  logic              mem_busywait_i
);

  typedef enum logic [1:0] {IDLE, MEM_READ, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid0_q, valid0_d;
  logic [SETS-1:0]   valid1_q, valid1_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [BLK_W-1:0]  line_addr_q, line_addr_d;
  logic              flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]  tag0_q  [SETS];
  logic [TAG_W-1:0]  tag1_q  [SETS];
  logic [LINE_W-1:0] data0_q [SETS];
  logic [LINE_W-1:0] data1_q [SETS];

  // Lookup fields of the live PC
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word;
  logic              hit0, hit1, hit;
  logic [LINE_W-1:0] hit_line;

  assign idx  = pc_i[OFF_W+IDX_W-1:OFF_W];
  assign tag  = pc_i[ADDR_W-1:OFF_W+IDX_W];
  assign word = pc_i[OFF_W-1:2];

  logic unused_pc;
  assign unused_pc = ^{pc_i[31:ADDR_W], pc_i[1:0]};

  assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_line = hit1 ? data1_q[idx] : data0_q[idx];

  // Refill always targets the latched line address, never the live PC
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             victim;
  logic             fill_en;

  assign fill_idx = line_addr_q[IDX_W-1:0];
  assign fill_tag = line_addr_q[BLK_W-1:IDX_W];
  assign fill_en  = (state_q == MEM_READ) && !mem_busywait_i;

  always_comb begin
    if (!valid0_q[fill_idx])      victim = 1'b0;
    else if (!valid1_q[fill_idx]) victim = 1'b1;
    else                          victim = lru_q[fill_idx];
  end

  always_comb begin
    state_d       = state_q;
    valid0_d      = valid0_q;
    valid1_d      = valid1_q;
    lru_d         = lru_q;
    line_addr_d   = line_addr_q;
    flush_pend_d  = flush_pend_q;
    instruction_o = '0;
    busywait_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_address_o = '0;

    unique case (state_q)
      IDLE: begin
        if (pc_req_i) begin
          if (hit) begin
            instruction_o = hit_line[{word, 5'b0} +: 32];
            // LRU names the way that was not just used
            lru_d[idx]    = hit0;
          end else begin
            busywait_o    = 1'b1;
          end
        end
        if (flush_i) begin
          state_d = FLUSH;
        end else if (pc_req_i && !hit) begin
          state_d     = MEM_READ;
          line_addr_d = {tag, idx};
        end
      end

      MEM_READ: begin
        busywait_o    = 1'b1;
        mem_read_o    = 1'b1;
        mem_address_o = line_addr_q;
        flush_pend_d  = flush_pend_q | flush_i;
        if (!mem_busywait_i) begin
          if (victim) valid1_d[fill_idx] = 1'b1;
          else        valid0_d[fill_idx] = 1'b1;
          lru_d[fill_idx] = ~victim;
          flush_pend_d    = 1'b0;
          // A flush seen at any point during the refill runs right after it
          state_d         = (flush_pend_q | flush_i) ? FLUSH : IDLE;
        end
      end

      FLUSH: begin
        busywait_o = 1'b1;
        valid0_d   = '0;
        valid1_d   = '0;
        lru_d      = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      line_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      lru_q        <= lru_d;
      line_addr_q  <= line_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag/data storage needs no reset: contents are qualified by the valid bits,
  // and reset forces IDLE so an in-flight refill is never written.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      if (victim) begin
        tag1_q[fill_idx]  <= fill_tag;
        data1_q[fill_idx] <= mem_readdata_i;
      end else begin
        tag0_q[fill_idx]  <= fill_tag;
        data0_q[fill_idx] <= mem_readdata_i;
      end
    end
  end

endmodule
